// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier: ALU control codes used by
// both aludec and mult_unit, plus the multiplier FSM state type.
package mult_pkg;

    localparam logic [4:0] ALU_MULT  = 5'b10011;
    localparam logic [4:0] ALU_MULTU = 5'b10101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_unit_if.sv
// Request/response bundle between the datapath (master) and the multiplier
// (slave): request strobe, operands, status flags and the HI/LO results.
interface mult_unit_if #(parameter int WIDTH = 32);

    logic             start;
    logic [4:0]       alucontrol;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, alucontrol, srca, srcb,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, alucontrol, srca, srcb,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_unit.sv
// Radix-2 shift-add multiplier for MULT/MULTU: one multiplier bit per cycle,
// signed operands handled as magnitudes with a final sign fix into HI/LO.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    mult_unit_if.slave  bus
);

    mult_state_t          state_r;
    logic [2*WIDTH:0]     acc_r;
    logic [WIDTH-1:0]     mcand_r;
    logic                 neg_r;
    logic [5:0]           cnt_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 is_mul_s;
    logic                 is_signed_s;
    logic                 accept_s;
    logic                 last_iter_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH:0]     acc_next_s;
    logic [2*WIDTH-1:0]   prod_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    assign is_signed_s = (bus.alucontrol == ALU_MULT);
    assign is_mul_s    = is_signed_s || (bus.alucontrol == ALU_MULTU);
    assign accept_s    = bus.start && is_mul_s && (state_r != ST_RUN);
    assign last_iter_s = (cnt_r == 6'(WIDTH - 1));
    assign mag_a_s     = magnitude(bus.srca, is_signed_s);
    assign mag_b_s     = magnitude(bus.srcb, is_signed_s);

    // Add the multiplicand into the upper half when the current multiplier bit is set, then shift right.
    always_comb begin
        sum_s = acc_r[2*WIDTH:WIDTH];
        if (acc_r[0]) begin
            sum_s = acc_r[2*WIDTH:WIDTH] + {1'b0, mcand_r};
        end else begin
            sum_s = acc_r[2*WIDTH:WIDTH];
        end
        acc_next_s = {1'b0, sum_s, acc_r[WIDTH-1:1]};
    end

    // Sign fix of the final magnitude product for MULT with differing operand signs.
    always_comb begin
        prod_s = acc_next_s[2*WIDTH-1:0];
        if (neg_r) begin
            prod_s = -acc_next_s[2*WIDTH-1:0];
        end else begin
            prod_s = acc_next_s[2*WIDTH-1:0];
        end
    end

    // FSM, datapath and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            acc_r   <= {(2*WIDTH+1){1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            neg_r   <= 1'b0;
            cnt_r   <= 6'd0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        mcand_r <= mag_a_s;
                        acc_r   <= {{(WIDTH+1){1'b0}}, mag_b_s};
                        neg_r   <= is_signed_s && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
                        cnt_r   <= 6'd0;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (last_iter_s) begin
                        hi_r    <= prod_s[2*WIDTH-1:WIDTH];
                        lo_r    <= prod_s[WIDTH-1:0];
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state_r == ST_RUN);
    assign bus.done = (state_r == ST_DONE);
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: product table plus hand sequences for
// mid-run start, invalid codes, back-to-back accept and reset abort.
module tb_mult_unit;

    localparam logic [4:0] C_MULT  = 5'b10011;
    localparam logic [4:0] C_MULTU = 5'b10101;

    logic clk;
    logic reset;

    mult_unit_if #(.WIDTH(32)) bus ();

    mult_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [11];
    int   n_cmp;
    int   n_err;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one accept across a clock edge; returns sampled in cycle 1.
    task automatic accept(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        bus.start      = 1'b1;
        bus.alucontrol = ctrl;
        bus.srca       = a;
        bus.srcb       = b;
        tick();
        bus.start      = 1'b0;
    endtask

    // Count edges until done (bounded) and busy cycles seen on the way.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (!bus.done && n < 80) begin
            if (bus.busy) bc++;
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int bc;
        logic saw_done;

        n_cmp = 0;
        n_err = 0;
        bus.start      = 1'b0;
        bus.alucontrol = 5'b00000;
        bus.srca       = 32'h0;
        bus.srcb       = 32'h0;

        vecs[0]  = '{C_MULTU, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
        vecs[1]  = '{C_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{C_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3]  = '{C_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4]  = '{C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[5]  = '{C_MULTU, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[6]  = '{C_MULT,  32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[7]  = '{C_MULT,  32'h00000005, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[8]  = '{C_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[9]  = '{C_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[10] = '{C_MULTU, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A};

        reset = 1'b0;
        tick();
        tick();
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b1;
        tick();
        prev_hi = 32'h0;
        prev_lo = 32'h0;

        for (int i = 0; i < 11; i++) begin
            accept(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy1", i), {63'd0, bus.busy}, 64'd1);
            chk($sformatf("v%0d_oldprod", i), {bus.hi, bus.lo}, {prev_hi, prev_lo});
            wait_done(n, bc);
            chk($sformatf("v%0d_latency", i), 64'(n), 64'd32);
            chk($sformatf("v%0d_busycnt", i), 64'(bc), 64'd32);
            chk($sformatf("v%0d_busy_at_done", i), {63'd0, bus.busy}, 64'd0);
            chk($sformatf("v%0d_prod", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
            tick();
            chk($sformatf("v%0d_done_pulse", i), {62'd0, bus.done, bus.busy}, 64'd0);
            prev_hi = vecs[i].hi;
            prev_lo = vecs[i].lo;
        end

        // Start while running is ignored.
        accept(C_MULTU, 32'd2, 32'd2);
        repeat (9) tick();
        accept(C_MULTU, 32'd7, 32'd7);
        wait_done(n, bc);
        chk("midrun_latency", 64'(n), 64'd22);
        chk("midrun_prod", {bus.hi, bus.lo}, 64'd4);
        tick();

        // Non-multiply code in IDLE is ignored.
        accept(5'b00010, 32'd3, 32'd3);
        chk("badcode_busy", {63'd0, bus.busy}, 64'd0);
        tick();
        chk("badcode_idle", {62'd0, bus.done, bus.busy}, 64'd0);

        // Back-to-back accept in the done cycle.
        accept(C_MULTU, 32'd3, 32'd5);
        wait_done(n, bc);
        chk("b2b_first_done", {63'd0, bus.done}, 64'd1);
        accept(C_MULTU, 32'd4, 32'd4);
        chk("b2b_busy", {62'd0, bus.busy, bus.done}, 64'd2);
        wait_done(n, bc);
        chk("b2b_latency", 64'(n), 64'd32);
        chk("b2b_prod", {bus.hi, bus.lo}, 64'd16);
        tick();

        // Reset mid-run aborts with no late done.
        accept(C_MULTU, 32'd6, 32'd7);
        wait_done(n, bc);
        chk("pre_abort_prod", {bus.hi, bus.lo}, 64'd42);
        tick();
        accept(C_MULT, 32'd2, 32'd3);
        repeat (9) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_flags", {62'd0, bus.busy, bus.done}, 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("abort_no_done", {63'd0, saw_done}, 64'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b0;
        accept(C_MULTU, 32'd3, 32'd5);
        reset = 1'b1;
        chk("rst_prio_busy", {63'd0, bus.busy}, 64'd0);
        tick();
        chk("rst_prio_idle", {62'd0, bus.busy, bus.done}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-004 start  input  1  request strobe from decode/datapath, qualified by alucontrol.
REQ-005 alucontrol  input  5  ALU control code; MULT=5'b10011 (signed), MULTU=5'b10101 (unsigned).
REQ-006 srca  input  WIDTH  multiplicand (rs).
REQ-007 srcb  input  WIDTH  multiplier (rt).
REQ-008 busy  output  1  multiply in progress; datapath stalls on busy.
REQ-009 done  output  1  single-cycle pulse, HI/LO hold the new product.
REQ-010 hi  output  WIDTH  upper half of the last completed product (mfhi source).
REQ-011 lo  output  WIDTH  lower half of the last completed product (mflo source).

Function
REQ-012 FSM states IDLE, RUN, DONE; encoding is free.
REQ-013 Accept: start=1 and alucontrol is MULT or MULTU, in IDLE or DONE -> latch operands, clear the iteration counter, go to RUN.
REQ-014 start with any other alucontrol code is ignored in every state.
REQ-015 start in RUN is ignored; latched operands are not disturbed.
REQ-016 RUN performs a radix-2 shift-add, one multiplier bit per cycle, WIDTH cycles, 6-bit counter 0..WIDTH-1.
REQ-017 After the iteration with counter = WIDTH-1, the FSM goes to DONE and hi/lo are written on the same edge.
REQ-018 MULT: operands are converted to magnitudes at accept; the 2*WIDTH result is two's-complement negated before the write when the operand signs differ.
REQ-019 MULTU: operands are treated as unsigned; no negation.
REQ-020 The product is an exact 2*WIDTH-bit result; the accumulator is 2*WIDTH+1 bits to absorb the carry.
REQ-021 Latency: accept at edge 0 -> busy=1 during cycles 1..WIDTH; done=1 and hi/lo valid in cycle WIDTH+1.
REQ-022 done is high only in DONE; DONE -> IDLE next cycle unless a new accept occurs (REQ-013).
REQ-023 busy=1 exactly in RUN; busy and done are never high together.
REQ-024 hi/lo hold their previous values until the completing edge; reads during RUN return the old product.
REQ-025 A zero operand still takes the full WIDTH cycles; there is no early termination.
REQ-026 MULT with -2^(WIDTH-1) times -2^(WIDTH-1) yields 2^(2*WIDTH-2) with no overflow.

Reset
REQ-027 reset=0 at a rising edge forces IDLE; busy=0, done=0, hi=0, lo=0, counter=0, accumulator=0.
REQ-028 Reset during RUN aborts the operation; no partial product reaches hi/lo.
REQ-029 Reset has priority over start on the same edge.

Structure
REQ-030 Shared package mult_pkg holds ALU codes ALU_MULT and ALU_MULTU (shared with aludec) and the state enum type mult_state_t.
REQ-031 The module is a single block with no sub-modules; the datapath is the accumulator/shift register, counter and sign-fix negator.
REQ-032 All state is updated in one clocked process; outputs are registered, except busy and done, which decode directly from the state.

Verification
REQ-033 MULTU 3 x 5, accept at cycle 0 -> busy cycles 1..32, done at cycle 33, hi=0x00000000, lo=0x0000000F.
REQ-034 MULT 0xFFFFFFF9 (-7) x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0xFFFFFFFF x 0xFFFFFFFF -> hi=0, lo=1.
REQ-035 MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 Accept MULTU 2x2; at cycle 10 pulse start with MULTU 7x7 -> ignored, lo=4 at cycle 33; start with alucontrol=5'b00010 in IDLE -> busy stays 0.
REQ-037 Complete 6x7 (lo=42); start MULT 2x3; drive reset=0 at cycle 10 -> busy=0, done=0, hi=lo=0 next cycle, no done pulse follows.
REQ-038 Back-to-back: start MULTU 4x4 in the done cycle of a prior op -> accepted, next done 33 cycles later, lo=16.
